// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, controller states, flag positions and op latency for alu_req_ctrl
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_MOD = 4'd5,
    OP_ADD = 4'd6,
    OP_SUB = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9,
    OP_CLR = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  // rsp_flags layout is {C,V,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam logic [3:0] ALU_OP_ILLEGAL = 4'd15;
  localparam logic [3:0] FLAGS_ERR      = 4'b0001;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_DIV) || (op == OP_CLR);
  endfunction

  function automatic int op_latency(input logic [3:0] op, input int mul_lat, input int div_lat);
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant; pointer moves past the served requester
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_serve,
  input  logic       i_served_id,
  output logic       o_any,
  output logic       o_grant_id
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_serve) begin
      r_ptr <= ~i_served_id;
    end
  end

  assign o_any      = |i_req;
  assign o_grant_id = i_req[r_ptr] ? r_ptr : ~r_ptr;

endmodule

// File: rtl/alu_req_ctrl.sv
// rtl/alu_req_ctrl.sv - shares one external ALU between two requesters with valid/ready responses
// Option ALU_DIV0_CHECK_EN: MOD/DIV with b==0 skips EXEC and returns an error response.
module alu_req_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_y,
  output logic [N-1:0] rsp_x,
  output logic [N-1:0] rsp_z,
  output logic [N-1:0] rsp_w,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         busy,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_y,
  input  logic [N-1:0] alu_x,
  input  logic [N-1:0] alu_z,
  input  logic [N-1:0] alu_w,
  input  logic         alu_c,
  input  logic         alu_v,
  input  logic         alu_n
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [3:0]       r_op;
  logic             r_id;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0] r_y;
  logic [N-1:0] r_x;
  logic [N-1:0] r_z;
  logic [N-1:0] r_w;
  logic [3:0]   r_flags;
  logic         r_err;

  logic         w_any;
  logic         w_grant_id;
  logic         w_accept;
  logic         w_serve;
  logic         w_div0;
  logic [N-1:0] w_sel_a;
  logic [N-1:0] w_sel_b;
  logic [3:0]   w_sel_op;

  logic [N-1:0] w_cap_y;
  logic [N-1:0] w_cap_x;
  logic [N-1:0] w_cap_z;
  logic [N-1:0] w_cap_w;
  logic [3:0]   w_cap_flags;
  logic         w_cap_err;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       ({req1_valid, req0_valid}),
    .i_serve     (w_serve),
    .i_served_id (r_id),
    .o_any       (w_any),
    .o_grant_id  (w_grant_id)
  );

  assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
  assign w_sel_b  = w_grant_id ? req1_b  : req0_b;
  assign w_sel_op = w_grant_id ? req1_op : req0_op;

  // Readies are gated by rst_n so every output reads 0 while reset is held.
  assign w_accept = rst_n && w_any && (r_state == ST_IDLE);
  assign w_serve  = (r_state == ST_RESP) && (r_id ? rsp1_ready : rsp0_ready);

`ifdef ALU_DIV0_CHECK_EN
  assign w_div0 = ((w_sel_op == OP_MOD) || (w_sel_op == OP_DIV)) && (w_sel_b == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    busy        = (r_state != ST_IDLE);
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_accept & ~w_grant_id;
        req1_ready = w_accept &  w_grant_id;
        if (w_accept) begin
          w_state_nxt = w_div0 ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_a  = r_a;
        alu_b  = r_b;
        alu_op = op_is_legal(r_op) ? r_op : ALU_OP_ILLEGAL;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid = ~r_id;
        rsp1_valid =  r_id;
        if (w_serve) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Only the words and flags that the opcode defines are kept; the rest read 0.
  always_comb begin
    w_cap_y     = '0;
    w_cap_x     = '0;
    w_cap_z     = '0;
    w_cap_w     = '0;
    w_cap_flags = FLAGS_ERR;
    w_cap_err   = 1'b1;
    if (op_is_legal(r_op)) begin
      w_cap_err = 1'b0;
      w_cap_y   = alu_y;
      if ((r_op == OP_MUL) || (r_op == OP_DIV)) begin
        w_cap_x = alu_x;
      end
      if (r_op == OP_DIV) begin
        w_cap_z = alu_z;
        w_cap_w = alu_w;
      end
      w_cap_flags         = '0;
      w_cap_flags[FLAG_C] = (r_op == OP_ADD) && alu_c;
      w_cap_flags[FLAG_V] = ((r_op == OP_ADD) || (r_op == OP_SUB)) && alu_v;
      w_cap_flags[FLAG_N] = (r_op == OP_SUB) && alu_n;
      w_cap_flags[FLAG_Z] = (alu_y == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_z     <= '0;
      r_w     <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_op  <= w_sel_op;
            r_id  <= w_grant_id;
            r_cnt <= CNT_W'(op_latency(w_sel_op, MUL_LAT, DIV_LAT));
            if (w_div0) begin
              r_y     <= '0;
              r_x     <= '0;
              r_z     <= '0;
              r_w     <= '0;
              r_flags <= FLAGS_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_y     <= w_cap_y;
            r_x     <= w_cap_x;
            r_z     <= w_cap_z;
            r_w     <= w_cap_w;
            r_flags <= w_cap_flags;
            r_err   <= w_cap_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_y     = r_y;
  assign rsp_x     = r_x;
  assign rsp_z     = r_z;
  assign rsp_w     = r_w;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_err;

endmodule

// File: doc/alu_req_ctrl.md
Name: alu_req_ctrl

Overview:
- Sequencing controller that shares one combinational N-bit ALU between two requesters (e.g. FSM host, switch/debug port).
- Round-robin arbitration; registers the granted operands and opcode, and drives them to the ALU for an op-dependent number of cycles.
- Captures the ALU result words and masked flags, then returns them through a valid/ready response handshake to the granted requester.
- Sits between the requesters and the ALU instance; the ALU stays outside this block.

Parameters:
N, 4, operand/result word width
MUL_LAT, 2, EXEC cycles for multiply (op 8), >=1
DIV_LAT, 5, EXEC cycles for divide (op 9), >=1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req0_valid / req1_valid  in  1  request pending
req0_ready / req1_ready  out  1  request accepted this cycle
req0_a, req0_b / req1_a, req1_b  in  N  operands
req0_op / req1_op  in  4  opcode
rsp0_valid / rsp1_valid  out  1  response available
rsp0_ready / rsp1_ready  in  1  response consumed
rsp_y, rsp_x, rsp_z, rsp_w  out  N  result words (y low/quotient, x high, z/w remainder)
rsp_flags  out  4  {C,V,N,Z}
rsp_err  out  1  illegal op (or div0, see option)
busy  out  1  state != IDLE
alu_a, alu_b  out  N  operands to ALU
alu_op  out  4  opcode to ALU
alu_y, alu_x, alu_z, alu_w  in  N  ALU result words
alu_c, alu_v, alu_n  in  1  ALU carry, overflow, negative

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at any edge, including mid-operation):
  - state=IDLE, rr pointer=0.
  - All outputs 0; any pending response is discarded.
- States IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is computed combinationally from the valids and the rr pointer; the pointer names the preferred requester.
  - reqK_ready=1 only in IDLE and only for the granted requester.
  - On accept: latch a, b, op and the requester id; load cnt=lat(op); go EXEC.
- lat(op):
  - ops 0-7: 1
  - op 8: MUL_LAT
  - op 9: DIV_LAT
  - op 15 (clear): 1
  - ops 10-14: illegal, 1
- EXEC:
  - alu_a/alu_b/alu_op are driven from the latched registers and held stable for every EXEC cycle.
  - For an illegal op, alu_op=15.
  - cnt decrements each cycle. At cnt==1: capture the ALU outputs, go RESP.
- Capture rules:
  - y is captured for all legal ops.
  - x captured for ops 8 and 9; z and w captured for op 9 only; uncaptured words are 0.
  - C = alu_c for op 6 only.
  - N = alu_n for op 7 only.
  - V = alu_v for ops 6 and 7 only.
  - Z = (captured y == 0).
  - Illegal op: all words 0, flags 4'b0001, rsp_err=1.
- RESP:
  - rspK_valid=1 for the latched id only; rsp_* held stable until rspK_ready.
  - On handshake: pointer = other requester, go IDLE.
  - No new request is accepted in EXEC or RESP.
- Latency and throughput:
  - Accept at edge t -> rsp valid from edge t+lat+1.
  - Minimum spacing between accepts is lat+2 cycles.
- Protocol: a requester must hold valid and its payload until accepted. Payload changes before acceptance are ignored, and only the value at acceptance is used.

Optional Feature:
- Macro ALU_DIV0_CHECK_EN.
- Defined: op 5 or 9 with b==0 skips EXEC; go straight to RESP one edge after accept, with words 0, flags 4'b0001, rsp_err=1.
- Undefined: executed normally with the normal latency; rsp_err=0; results are whatever the ALU produces.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode enum: OP_AND=0, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOD, OP_ADD, OP_SUB, OP_MUL, OP_DIV=9, OP_CLR=15
  - state enum
  - flag bit index constants
  - function op_latency(op)
- Sub-module rr_arbiter2: two-input round-robin grant, with pointer update on the serve strobe.

Test Plan:
- Add: req0 a=7, b=9, op=6, alu_c=1, alu_v=0, alu_y=0 -> rsp0_valid exactly 2 cycles after accept; y=0, flags=4'b1001, err=0.
- Arbitration: after reset, both valid simultaneously -> req0 served first, then req1. Then, with both re-asserted after req1 is served, req0 is granted first again (pointer=0).
- Divide: req1 a=13, b=3, op=9 with ALU model -> rsp1_valid 6 cycles after accept; y=4, x=0, z=1, w=0; alu_op=9 held for 5 cycles.
- Backpressure: rsp0_ready low for 5 cycles while req1_valid=1 -> rsp fields stable, req1_ready=0 throughout; req1 is accepted in the first cycle after the handshake.
- Illegal op 4'b1010 -> alu_op=15, rsp err=1, flags=4'b0001, all words 0. With ALU_DIV0_CHECK_EN: op 9, b=0 -> rsp 1 cycle after accept, err=1.
- Reset mid-divide (rst_n low in 3rd EXEC cycle) -> next edge busy=0, all outputs 0, no rsp_valid; the pointer returns to 0.
